// File: rtl/i2c_txn_seq.sv
// i2c_txn_seq: expands one register read/write request into the byte sequence
// for the byte-level I2C engine, with a per-byte watchdog that can reset the engine.
module i2c_txn_seq #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic        rd_not_wr,
    input  logic [6:0]  dev_addr,
    input  logic [7:0]  reg_addr,
    input  logic [7:0]  wr_data,
    input  logic [2:0]  rd_len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rd_data,
    output logic        byte_run,
    input  logic        byte_busy,
    output logic [7:0]  byte_wr,
    input  logic [7:0]  byte_rd,
    output logic        ack_out,
    output logic        add_stop,
    output logic        add_rpt_start,
    output logic        eng_rst_n
);
    localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_NEXT, S_DONE, S_ABORT
    } state_t;

    state_t      r_state;
    logic        r_rd;
    logic [6:0]  r_dev;
    logic [7:0]  r_reg;
    logic [7:0]  r_wdat;
    logic [2:0]  r_last;
    logic [2:0]  r_k;
    logic [15:0] r_wdog;
    logic [1:0]  r_acnt;

    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rd_data;
    logic        r_byte_run;
    logic [7:0]  r_byte_wr;
    logic        r_ack_out;
    logic        r_add_stop;
    logic        r_add_rpt_start;
    logic        r_eng_rst_n;

    logic [2:0]  w_nrd;
    logic [2:0]  w_last_idx;
    logic        w_is_last;
    logic        w_is_read;
    logic        w_wdog_exp;
    logic [7:0]  w_bwr;
    logic        w_ack;
    logic        w_stop;
    logic        w_rpt;

    always_comb begin
        w_nrd      = (rd_len == 3'd0) ? 3'd1 : ((rd_len > 3'd4) ? 3'd4 : rd_len);
        w_last_idx = rd_not_wr ? (3'd2 + w_nrd) : 3'd2;
        w_is_last  = (r_k == r_last);
        w_is_read  = r_rd && (r_k >= 3'd3);
        w_wdog_exp = (r_wdog >= (TIMEOUT - 16'd1));
    end

    // Byte k of the transaction: addr(W), reg, then either data+stop or addr(R) and reads.
    always_comb begin
        w_bwr  = 8'hFF;
        w_ack  = 1'b0;
        w_stop = 1'b0;
        w_rpt  = 1'b0;
        case (r_k)
            3'd0: w_bwr = {r_dev, 1'b0};
            3'd1: begin
                w_bwr = r_reg;
                w_rpt = r_rd;
            end
            3'd2: begin
                w_bwr  = r_rd ? {r_dev, 1'b1} : r_wdat;
                w_stop = !r_rd;
            end
            default: begin
                w_ack  = !w_is_last;
                w_stop = w_is_last;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state         <= S_IDLE;
            r_rd            <= 1'b0;
            r_dev           <= '0;
            r_reg           <= '0;
            r_wdat          <= '0;
            r_last          <= '0;
            r_k             <= '0;
            r_wdog          <= '0;
            r_acnt          <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_rd_data       <= '0;
            r_byte_run      <= 1'b0;
            r_byte_wr       <= 8'hFF;
            r_ack_out       <= 1'b0;
            r_add_stop      <= 1'b0;
            r_add_rpt_start <= 1'b0;
            r_eng_rst_n     <= 1'b1;
        end else begin
            r_done     <= 1'b0;
            r_byte_run <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rd      <= rd_not_wr;
                        r_dev     <= dev_addr;
                        r_reg     <= reg_addr;
                        r_wdat    <= wr_data;
                        r_last    <= w_last_idx;
                        r_k       <= '0;
                        r_rd_data <= '0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_byte_wr       <= w_bwr;
                    r_ack_out       <= w_ack;
                    r_add_stop      <= w_stop;
                    r_add_rpt_start <= w_rpt;
                    r_byte_run      <= 1'b1;
                    r_state         <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (r_wdog != TIMEOUT) r_wdog <= r_wdog + 16'd1;
                    if (w_wdog_exp) begin
                        r_err       <= 1'b1;
                        r_eng_rst_n <= 1'b0;
                        r_acnt      <= '0;
                        r_state     <= S_ABORT;
                    end else if (byte_busy) begin
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (r_wdog != TIMEOUT) r_wdog <= r_wdog + 16'd1;
                    if (!byte_busy) begin
                        if (w_is_read) r_rd_data <= {r_rd_data[23:0], byte_rd};
                        r_state <= S_NEXT;
                    end else if (w_wdog_exp) begin
                        r_err       <= 1'b1;
                        r_eng_rst_n <= 1'b0;
                        r_acnt      <= '0;
                        r_state     <= S_ABORT;
                    end
                end
                S_NEXT: begin
                    if (w_is_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_k     <= r_k + 3'd1;
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                S_ABORT: begin
                    // Engine reset is held for four cycles, then we wait for it to go idle.
                    if (r_acnt != 2'd3) begin
                        r_acnt <= r_acnt + 2'd1;
                    end else begin
                        r_eng_rst_n <= 1'b1;
                        if (!byte_busy) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign rd_data       = r_rd_data;
    assign byte_run      = r_byte_run;
    assign byte_wr       = r_byte_wr;
    assign ack_out       = r_ack_out;
    assign add_stop      = r_add_stop;
    assign add_rpt_start = r_add_rpt_start;
    assign eng_rst_n     = r_eng_rst_n;

endmodule

// File: tb/tb_i2c_txn_seq.sv
// Bench for i2c_txn_seq: engine/slave model, table and random transactions,
// plus NAK timeout, ignored restart and mid-transaction reset sequences.
module tb_i2c_txn_seq;
    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        start = 1'b0;
    logic        rd_not_wr = 1'b0;
    logic [6:0]  dev_addr = '0;
    logic [7:0]  reg_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [2:0]  rd_len = '0;
    logic        busy, done, err;
    logic [31:0] rd_data;
    logic        byte_run;
    logic        byte_busy;
    logic [7:0]  byte_wr;
    logic [7:0]  byte_rd;
    logic        ack_out, add_stop, add_rpt_start, eng_rst_n;

    always #5 clk = ~clk;

    i2c_txn_seq #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .rd_not_wr(rd_not_wr),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data), .rd_len(rd_len),
        .busy(busy), .done(done), .err(err), .rd_data(rd_data),
        .byte_run(byte_run), .byte_busy(byte_busy), .byte_wr(byte_wr), .byte_rd(byte_rd),
        .ack_out(ack_out), .add_stop(add_stop), .add_rpt_start(add_rpt_start),
        .eng_rst_n(eng_rst_n)
    );

    typedef struct {
        logic        rd;
        logic [6:0]  dev;
        logic [7:0]  rg;
        logic [7:0]  wd;
        logic [2:0]  len;
        logic [31:0] slv;        // slave read bytes, first byte in [31:24]
        logic [31:0] exp_rdata;
        int          exp_nbytes;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference model
    function automatic int nreads(input logic rd, input logic [2:0] len);
        if (!rd) return 0;
        if (len == 3'd0) return 1;
        if (len > 3'd4) return 4;
        return int'(len);
    endfunction

    // {byte, ack_out, add_stop, add_rpt_start} expected for byte j
    function automatic logic [10:0] exp_byte(input logic rd, input logic [6:0] dev,
                                             input logic [7:0] rg, input logic [7:0] wd,
                                             input int n, input int j);
        int   total;
        logic last;
        total = 3 + n;
        last  = (j == total - 1);
        if (j == 0) return {dev, 1'b0, 3'b000};
        if (j == 1) return {rg, 2'b00, rd};
        if (j == 2) return rd ? {dev, 1'b1, 3'b000} : {wd, 3'b010};
        return {8'hFF, !last, last, 1'b0};
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] slv, input int n);
        logic [31:0] acc;
        logic [7:0]  b;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            b   = slv[31-8*i -: 8];
            acc = acc | (32'(b) << (8 * (n - 1 - i)));
        end
        return acc;
    endfunction

    // Engine + slave model, updated on the falling edge
    logic [10:0] log_q[$];
    logic [7:0]  slave_rd [4];
    bit          nak_mode = 1'b0;
    bit          pend = 1'b0;
    int          hold = 0;

    initial begin
        byte_busy = 1'b0;
        byte_rd   = 8'h00;
        forever begin
            @(negedge clk);
            if (!n_reset || !eng_rst_n) begin
                byte_busy = 1'b0;
                pend      = 1'b0;
            end else if (byte_run) begin
                chk("run_idle_engine", {30'd0, pend, byte_busy}, 32'd0);
                log_q.push_back({byte_wr, ack_out, add_stop, add_rpt_start});
                pend = 1'b1;
                hold = $urandom_range(5, 2);
            end else if (pend && !byte_busy) begin
                byte_busy = 1'b1;
                byte_rd   = 8'($urandom);
            end else if (byte_busy && !(nak_mode && log_q.size() == 1)) begin
                hold--;
                if (hold == 0) begin
                    byte_busy = 1'b0;
                    pend      = 1'b0;
                    byte_rd   = (log_q.size() >= 4) ? slave_rd[log_q.size()-4] : 8'($urandom);
                end
            end
        end
    end

    int done_cnt = 0;
    int low_run = 0;
    int last_low = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (eng_rst_n === 1'b0) begin
                low_run++;
            end else if (low_run != 0) begin
                last_low = low_run;
                low_run  = 0;
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctrl"}, {24'd0, busy, done, err, byte_run, ack_out, add_stop, add_rpt_start, eng_rst_n},
            32'h01);
        chk({tag, "_byte_wr"}, {24'd0, byte_wr}, 32'hFF);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
    endtask

    task automatic launch(input vec_t v);
        int t;
        t = 0;
        while ((busy || done) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail_bound("idle_wait");
        for (int i = 0; i < 4; i++) slave_rd[i] = v.slv[31-8*i -: 8];
        log_q.delete();
        done_cnt  = 0;
        rd_not_wr = v.rd;
        dev_addr  = v.dev;
        reg_addr  = v.rg;
        wr_data   = v.wd;
        rd_len    = v.len;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        rd_not_wr = 1'($urandom);
        dev_addr  = 7'($urandom);
        reg_addr  = 8'($urandom);
        wr_data   = 8'($urandom);
        rd_len    = 3'($urandom);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("err_cleared", {31'd0, err}, 32'd0);
        chk("run_not_yet", {31'd0, byte_run}, 32'd0);
        @(negedge clk);
        chk("run_at_issue", {31'd0, byte_run}, 32'd1);
    endtask

    task automatic finish_check(input vec_t v);
        int t;
        int n;
        n = nreads(v.rd, v.len);
        t = 0;
        while (!done && !err && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("rd_data", rd_data, v.exp_rdata);
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("done_pulses", done_cnt, 32'd1);
        chk("err_clear", {31'd0, err}, 32'd0);
        chk("rd_data_hold", rd_data, v.exp_rdata);
        chk("byte_count", log_q.size(), v.exp_nbytes);
        for (int j = 0; j < log_q.size() && j < 7; j++)
            chk($sformatf("byte%0d", j), {21'd0, log_q[j]},
                {21'd0, exp_byte(v.rd, v.dev, v.rg, v.wd, n, j)});
    endtask

    initial begin
        vec_t tbl [4];
        vec_t v;
        int   t;
        int   n;

        tbl[0] = '{1'b0, 7'h48, 8'h01, 8'hA5, 3'd0, 32'h0000_0000, 32'h0000_0000, 3};
        tbl[1] = '{1'b1, 7'h48, 8'h00, 8'h00, 3'd2, 32'h1234_0000, 32'h0000_1234, 5};
        tbl[2] = '{1'b1, 7'h48, 8'h10, 8'h00, 3'd0, 32'h5A00_0000, 32'h0000_005A, 4};
        tbl[3] = '{1'b1, 7'h2A, 8'h33, 8'h00, 3'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 7};

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        n_reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_reset");

        for (int i = 0; i < 4; i++) begin
            launch(tbl[i]);
            finish_check(tbl[i]);
        end

        for (int i = 0; i < 30; i++) begin
            v.rd  = 1'($urandom);
            v.dev = 7'($urandom);
            v.rg  = 8'($urandom);
            v.wd  = 8'($urandom);
            v.len = 3'($urandom);
            v.slv = $urandom;
            n = nreads(v.rd, v.len);
            v.exp_rdata  = exp_rdata(v.slv, n);
            v.exp_nbytes = 3 + n;
            launch(v);
            finish_check(v);
        end

        // start pulsed again while busy must be ignored
        launch(tbl[0]);
        t = 0;
        while (log_q.size() < 2 && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        start     = 1'b1;
        rd_not_wr = 1'b1;
        dev_addr  = 7'h11;
        reg_addr  = 8'h22;
        wr_data   = 8'h33;
        rd_len    = 3'd4;
        @(negedge clk);
        start = 1'b0;
        finish_check(tbl[0]);
        repeat (20) @(negedge clk);
        chk("no_queued_txn", log_q.size(), 32'd3);
        chk("idle_after_restart", {31'd0, busy}, 32'd0);

        // Slave NAKs the address byte
        nak_mode = 1'b1;
        v = '{1'b0, 7'h50, 8'h02, 8'h77, 3'd0, 32'h0, 32'h0, 3};
        launch(v);
        t = 0;
        while (!byte_busy && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) fail_bound("nak_busy_rise");
        t = 0;
        while (!err && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("nak_err_latency_ok", {31'd0, (t <= 66)}, 32'd1);
        chk("nak_err_set", {31'd0, err}, 32'd1);
        t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        @(negedge clk);
        #1;
        chk("nak_busy_low", {31'd0, busy}, 32'd0);
        chk("eng_rst_low_cycles", last_low, 32'd4);
        chk("nak_no_done", done_cnt, 32'd0);
        chk("nak_err_sticky", {31'd0, err}, 32'd1);
        chk("nak_bytes", log_q.size(), 32'd1);
        nak_mode = 1'b0;
        launch(tbl[0]);
        finish_check(tbl[0]);

        // Reset while the second read byte is in flight
        v = '{1'b1, 7'h22, 8'h05, 8'h00, 3'd3, 32'hA1B2_C300, 32'h00A1_B2C3, 6};
        launch(v);
        t = 0;
        while (!(log_q.size() == 5 && byte_busy) && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 500) fail_bound("reset_point");
        @(posedge clk);
        #2;
        chk("pre_reset_ack", {31'd0, ack_out}, 32'd1);
        chk("pre_reset_rd_data", rd_data, 32'h0000_00A1);
        n_reset = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        log_q.delete();
        @(negedge clk);
        chk_reset_vals("after_release");
        launch(tbl[0]);
        finish_check(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
